inst_fetch: RTL and testbench

- Instruction-fetch stage of the rv5stage pipeline; produces the instruction words consumed by the decode stage.
- Owns the PC and issues word reads to instruction memory over a valid/ready request channel with a valid-only response channel.
- Holds at most one outstanding request, buffers up to two returned words (output register plus skid), and accepts redirects from execute.

---
 rtl/inst_fetch_pkg.sv | 11 +
 rtl/fetch_skid.sv | 31 +++
 rtl/inst_fetch.sv | 93 +++++++++
 tb/tb_inst_fetch.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch entry type, state encoding and default constants
package inst_fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_info_t;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL, S_HALT} fetch_state_e;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: single-entry fetch buffer with push/pop/flush and full flag
module fetch_skid
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_info_t din,
  output logic        full,
  output fetch_info_t dout
);
  logic        full_q, full_d;
  fetch_info_t data_q, data_d;
  always_comb begin
    full_d = ~flush & (push | (full_q & ~pop));
    data_d = push ? din : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign full = full_q;
  assign dout = data_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner issuing one imem request at a time into an output register plus skid
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  fetch_info_t  out_q, out_d, resp_info, skid_dout;
  logic         out_valid_q, out_valid_d;
  logic         skid_full, consume, hs, resp, skid_push, skid_pop;
  always_comb begin
    consume = out_valid_q & ~stall;
    imem_req_valid = ~rst & (state_q == S_REQ) & ~skid_full;
    imem_req_addr = pc_q;
    hs = imem_req_valid & imem_req_ready;
    resp = imem_resp_valid & (state_q == S_WAIT) & ~redirect_valid;
    // pc already advanced past the request in flight
    resp_info = '{pc: pc_q - 32'd4, inst: imem_resp_err ? NOP_INST : imem_resp_data, fault: imem_resp_err};
    skid_push = resp & out_valid_q & ~consume;
    skid_pop = consume & skid_full & ~redirect_valid;
    out_d = out_q;
    out_valid_d = out_valid_q & ~consume;
    if (redirect_valid) out_valid_d = 1'b0;
    else if (resp & ~skid_push) begin
      out_d = resp_info;
      out_valid_d = 1'b1;
    end else if (skid_pop) begin
      out_d = skid_dout;
      out_valid_d = 1'b1;
    end
    state_d = state_q;
    pc_d = pc_q;
    case (state_q)
      S_REQ: if (hs) begin
        state_d = S_WAIT;
        pc_d = pc_q + 32'd4;
      end
      S_WAIT: if (imem_resp_valid) state_d = imem_resp_err ? S_HALT : S_REQ;
      S_KILL: if (imem_resp_valid) state_d = S_REQ;
      default: ;
    endcase
    // a redirect must still swallow any response owed to an older request
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      state_d = (hs || ((state_q == S_WAIT || state_q == S_KILL) && !imem_resp_valid)) ? S_KILL : S_REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
  fetch_skid u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (skid_push),
    .pop  (skid_pop),
    .flush(redirect_valid),
    .din  (resp_info),
    .full (skid_full),
    .dout (skid_dout)
  );
  assign out_valid = out_valid_q;
  assign out_inst = out_q.inst;
  assign out_pc = out_q.pc;
  assign out_fault = out_q.fault;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plus randomized fetch traffic against a queue-based reference model
module tb_inst_fetch;
  import inst_fetch_pkg::*;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid, imem_resp_err;
  logic        stall, redirect_valid, out_valid, out_fault;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, out_inst, out_pc;
  int          checks = 0, failures = 0;
  fetch_info_t q[$];
  int          outstanding = 0, timer = 0, lat = 0;
  bit          stale = 0, halted = 0, rst_prev = 0, err_rand = 0;
  logic [31:0] exp_req = RST_PC, mem_addr = '0, err_addr = 32'h1;
  always #5 clk = ~clk;
  inst_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );
  function automatic logic [31:0] data_of(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // one clock: drive inputs and memory, check at negedge, then advance the model
  task automatic cyc(bit r, bit s, bit rdy, bit rv, logic [31:0] rp);
    bit hs;
    rst = r;
    stall = s;
    imem_req_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rp;
    imem_resp_valid = 1'b0;
    imem_resp_err = 1'b0;
    imem_resp_data = '0;
    if (!r && outstanding > 0) begin
      if (timer == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = data_of(mem_addr);
        imem_resp_err = err_rand ? ($urandom_range(0, 15) == 0) : (mem_addr == err_addr);
      end else timer--;
    end
    @(negedge clk);
    if (r) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'(0));
      if (rst_prev) begin
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_fault", 32'(out_fault), 32'(0));
      end
    end else begin
      chk("req_valid", 32'(imem_req_valid), 32'(outstanding == 0 && !halted && q.size() < 2));
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0 && out_valid) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_inst", out_inst, q[0].inst);
        chk("out_fault", 32'(out_fault), 32'(q[0].fault));
      end
    end
    hs = imem_req_valid && rdy;
    if (r) begin
      q.delete();
      outstanding = 0;
      stale = 0;
      halted = 0;
      exp_req = RST_PC;
    end else begin
      if (q.size() > 0 && !s) void'(q.pop_front());
      if (imem_resp_valid) begin
        outstanding = 0;
        if (!stale && !rv) begin
          q.push_back('{pc: mem_addr, inst: imem_resp_err ? NOP : imem_resp_data, fault: imem_resp_err});
          if (imem_resp_err) halted = 1;
        end
      end
      if (hs) begin
        outstanding = 1;
        stale = rv;
        mem_addr = imem_req_addr;
        exp_req = exp_req + 32'd4;
        timer = lat;
      end
      if (rv) begin
        q.delete();
        stale = 1;
        halted = 0;
        exp_req = {rp[31:2], 2'b00};
      end
    end
    rst_prev = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) cyc(1, 0, 1, 0, 0);
    repeat (10) cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(1, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0);
    repeat (6) cyc(0, 1, 1, 0, 0);
    repeat (8) cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(1, 0, 1, 0, 0);
    lat = 2;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 32'h0000_0103);
    repeat (12) cyc(0, 0, 1, 0, 0);
    lat = 0;
    err_addr = RST_PC + 32'd4;
    repeat (2) cyc(1, 0, 1, 0, 0);
    repeat (14) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 32'h0000_0040);
    repeat (8) cyc(0, 0, 1, 0, 0);
    err_addr = 32'h1;
    repeat (2) cyc(1, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0);
    repeat (2) cyc(1, 1, 1, 0, 0);
    repeat (6) cyc(0, 0, 1, 0, 0);
    err_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(0, 2);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 1) ? 32'($urandom) : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
